// File: rtl/fifo_rd_drain.sv
// Read-side drain stage behind the async FIFO: absorbs the pop latency in a 3-entry
// ring buffer and streams fixed-length packets. Optional checksum: FIFO_RD_DRAIN_CHKSUM_EN.
module fifo_rd_drain #(
    parameter int WIDTH   = 8,
    parameter int PKT_LEN = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] fifo_rdata_i,
    input  logic             fifo_empty_i,
    output logic             fifo_rd_en_o,
    input  logic             flush_i,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic             m_last_o,
    output logic [15:0]      pkt_cnt_o,
    output logic [WIDTH-1:0] chk_o,
    output logic             chk_valid_o
);
    localparam int                BEAT_W    = $clog2(PKT_LEN);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);

    logic [1:0]        occ_q, occ_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        wr_ptr_q, wr_ptr_d;
    logic [1:0]        rd_ptr_q, rd_ptr_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [15:0]       pkt_cnt_q, pkt_cnt_d;
    logic [WIDTH-1:0]  mem_q [3];
    logic [WIDTH-1:0]  mem_d [3];

    logic [2:0] pending;
    logic       capture;
    logic       consume;
    logic       pkt_done;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Pop decision looks only at registered state and the FIFO flag, never at m_ready_i.
    assign pending      = {1'b0, occ_q} + {2'b00, inflight_q};
    assign fifo_rd_en_o = rst_n_i && !fifo_empty_i && !flush_i && (pending < 3'd3);

    assign m_valid_o = (occ_q != 2'd0);
    assign m_data_o  = mem_q[rd_ptr_q];
    assign m_last_o  = m_valid_o && (beat_q == BEAT_LAST);
    assign pkt_cnt_o = pkt_cnt_q;

    assign capture  = inflight_q && !flush_i;
    assign consume  = m_valid_o && m_ready_i;
    assign pkt_done = consume && (beat_q == BEAT_LAST);

    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    always_comb begin
        occ_d      = occ_q;
        inflight_d = fifo_rd_en_o;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        beat_d     = beat_q;
        pkt_cnt_d  = pkt_cnt_q;
        mem_d      = mem_q;

        if (capture) begin
            mem_d[wr_ptr_q] = fifo_rdata_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (consume) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            beat_d   = pkt_done ? '0 : beat_q + BEAT_W'(1);
        end
        if (pkt_done) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end

        case ({capture, consume})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase

        // A completing handshake in the flush cycle still counts; everything else is dropped.
        if (flush_i) begin
            occ_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            beat_d   = '0;
        end
    end

    // NOTE: the buffer entries are reset as well so m_data_o reads 0 straight out of reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            occ_q      <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            beat_q     <= '0;
            pkt_cnt_q  <= '0;
            for (int i = 0; i < 3; i++) mem_q[i] <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            beat_q     <= beat_d;
            pkt_cnt_q  <= pkt_cnt_d;
            mem_q      <= mem_d;
        end
    end

`ifdef FIFO_RD_DRAIN_CHKSUM_EN
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] chk_q, chk_d;
    logic             chk_valid_q, chk_valid_d;

    always_comb begin
        acc_d       = acc_q;
        chk_d       = chk_q;
        chk_valid_d = 1'b0;
        if (consume) begin
            acc_d = pkt_done ? '0 : (acc_q ^ m_data_o);
        end
        if (pkt_done) begin
            chk_d       = acc_q ^ m_data_o;
            chk_valid_d = 1'b1;
        end
        if (flush_i) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q       <= '0;
            chk_q       <= '0;
            chk_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            chk_q       <= chk_d;
            chk_valid_q <= chk_valid_d;
        end
    end

    assign chk_o       = chk_q;
    assign chk_valid_o = chk_valid_q;
`else
    assign chk_o       = '0;
    assign chk_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: behavioural FIFO + stream scoreboard checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fifo_rd_drain;
    localparam int WIDTH   = 8;
    localparam int PKT_LEN = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] fifo_rdata = '0;
    logic             fifo_empty = 1'b1;
    logic             fifo_rd_en;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic             m_last;
    logic [15:0]      pkt_cnt;
    logic [WIDTH-1:0] chk;
    logic             chk_valid;

    always #5 clk = ~clk;

    fifo_rd_drain #(.WIDTH(WIDTH), .PKT_LEN(PKT_LEN)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .fifo_rdata_i (fifo_rdata),
        .fifo_empty_i (fifo_empty),
        .fifo_rd_en_o (fifo_rd_en),
        .flush_i      (flush),
        .m_data_o     (m_data),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .m_last_o     (m_last),
        .pkt_cnt_o    (pkt_cnt),
        .chk_o        (chk),
        .chk_valid_o  (chk_valid)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        int         pop_cyc;
    } ent_t;

    logic [7:0] fifo_q [$];
    ent_t       exp_q [$];
    logic [7:0] seen_data [$];
    logic       seen_last [$];
    int         seen_cyc [$];

    int          cyc = 0;
    int          pops = 0;
    int          mdl_beat = 0;
    logic [15:0] mdl_pkt = '0;
    logic [7:0]  mdl_acc = '0;
    logic [7:0]  mdl_chk = '0;
    int          mdl_chk_cyc = -1;
    int          chk_pulses = 0;
    logic        exp_valid;

    // FIFO read port model and expected-stream scoreboard, advanced once per edge.
    always @(posedge clk) begin
        ent_t e;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            seen_data.delete();
            seen_last.delete();
            seen_cyc.delete();
            pops        = 0;
            mdl_beat    = 0;
            mdl_pkt     = '0;
            mdl_acc     = '0;
            mdl_chk     = '0;
            mdl_chk_cyc = -1;
        end else begin
            if (m_valid && m_ready) begin
                seen_data.push_back(m_data);
                seen_last.push_back(m_last);
                seen_cyc.push_back(cyc);
                if (exp_q.size() > 0) begin
                    mdl_acc = mdl_acc ^ exp_q[0].data;
                    void'(exp_q.pop_front());
                end
                if (mdl_beat == PKT_LEN - 1) begin
                    mdl_beat    = 0;
                    mdl_pkt     = mdl_pkt + 16'd1;
                    mdl_chk     = mdl_acc;
                    mdl_acc     = '0;
                    mdl_chk_cyc = cyc;
                end else begin
                    mdl_beat++;
                end
            end
            if (flush) begin
                exp_q.delete();
                mdl_beat = 0;
                mdl_acc  = '0;
            end
            if (fifo_rd_en) begin
                if (fifo_q.size() == 0) begin
                    check("pop_while_empty", 32'd1, 32'd0);
                end else begin
                    e.data    = fifo_q.pop_front();
                    e.pop_cyc = cyc;
                    fifo_rdata <= e.data;
                    exp_q.push_back(e);
                    pops++;
                end
            end
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Per-cycle comparison against the scoreboard, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_valid = (exp_q.size() > 0) && (exp_q[0].pop_cyc < cyc);
            check("m_valid", m_valid, exp_valid);
            if (exp_valid) check("m_data", m_data, exp_q[0].data);
            check("m_last", m_last, exp_valid && (mdl_beat == PKT_LEN - 1));
            check("pkt_cnt", pkt_cnt, mdl_pkt);
            check("outstanding_le_3", exp_q.size() <= 3, 1'b1);
`ifdef FIFO_RD_DRAIN_CHKSUM_EN
            check("chk_valid", chk_valid, mdl_chk_cyc == cyc);
            check("chk_o", chk, mdl_chk);
`else
            check("chk_valid_tied", chk_valid, 1'b0);
            check("chk_o_tied", chk, 8'h00);
`endif
            if (chk_valid) chk_pulses++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        fifo_q.push_back(d);
    endtask

    task automatic check_reset_outputs();
        check("rst_rd_en", fifo_rd_en, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_last", m_last, 1'b0);
        check("rst_m_data", m_data, 8'h00);
        check("rst_pkt_cnt", pkt_cnt, 16'h0000);
        check("rst_chk", chk, 8'h00);
        check("rst_chk_valid", chk_valid, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        check_reset_outputs();
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        int p0;

        // 1: reset held while the FIFO has 5 words queued.
        tick(1);
        for (int i = 0; i < 5; i++) push(8'hC1 + 8'(i));
        tick(3);
        check_reset_outputs();
        rst_n = 1'b1;
        #1;
        check("rd_en_after_reset", fifo_rd_en, 1'b1);
        m_ready = 1'b1;
        tick(10);
        check("t1_words", seen_data.size(), 5);
        check("t1_pkt_cnt", pkt_cnt, 16'd1);

        // 2: full-rate drain of 8 words after a mid-packet reset.
        do_reset();
        for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
        tick(16);
        check("t2_words", seen_data.size(), 8);
        check("t2_word3", seen_data[3], 8'h44);
        check("t2_last3", seen_last[3], 1'b1);
        check("t2_last0", seen_last[0], 1'b0);
        check("t2_last7", seen_last[7], 1'b1);
        check("t2_word7", seen_data[7], 8'h88);
        check("t2_back_to_back", seen_cyc[7] - seen_cyc[0], 7);
        check("t2_pkt_cnt", pkt_cnt, 16'd2);

        // 3: backpressure with 10 words queued.
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) push(8'hA0 + 8'(i));
        tick(10);
        check("t3_pops", pops, 3);
        check("t3_valid", m_valid, 1'b1);
        check("t3_head", m_data, 8'hA0);
        m_ready = 1'b1;
        tick(25);
        check("t3_words", seen_data.size(), 10);
        for (int i = 0; i < 10; i++) check("t3_order", seen_data[i], 8'hA0 + 8'(i));
        check("t3_pkt_cnt", pkt_cnt, 16'd2);

        // 4: FIFO runs empty mid-packet.
        do_reset();
        push(8'h31);
        push(8'h32);
        tick(10);
        check("t4_gap_valid", m_valid, 1'b0);
        check("t4_gap_pkt", pkt_cnt, 16'd0);
        push(8'h33);
        push(8'h34);
        tick(8);
        check("t4_words", seen_data.size(), 4);
        check("t4_last1", seen_last[1], 1'b0);
        check("t4_last3", seen_last[3], 1'b1);
        check("t4_pkt_cnt", pkt_cnt, 16'd1);

        // 5: flush with two buffered words and one in flight, one beat into a packet.
        do_reset();
        push(8'h50);
        tick(5);
        check("t5_pre_words", seen_data.size(), 1);
        m_ready = 1'b0;
        p0 = pops;
        for (int i = 1; i <= 7; i++) push(8'h50 + 8'(i));
        tick(4);
        check("t5_pops_before_flush", pops - p0, 3);
        check("t5_valid_before_flush", m_valid, 1'b1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("t5_valid_after_flush", m_valid, 1'b0);
        m_ready = 1'b1;
        tick(12);
        check("t5_words", seen_data.size(), 5);
        check("t5_first_after_flush", seen_data[1], 8'h54);
        check("t5_last_first", seen_last[1], 1'b0);
        check("t5_last_fourth", seen_last[4], 1'b1);
        check("t5_pkt_cnt", pkt_cnt, 16'd1);

        // 6: checksum over 0x01, 0x02, 0x04, 0x08.
        do_reset();
        chk_pulses = 0;
        push(8'h01);
        push(8'h02);
        push(8'h04);
        push(8'h08);
        tick(10);
`ifdef FIFO_RD_DRAIN_CHKSUM_EN
        check("t6_chk", chk, 8'h0F);
        check("t6_chk_pulses", chk_pulses, 1);
`else
        check("t6_chk_off", chk, 8'h00);
        check("t6_chk_pulses_off", chk_pulses, 0);
`endif
        check("t6_pkt_cnt", pkt_cnt, 16'd1);

        // 7: random ready with a stream of 40 words.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            if (i < 40) push(8'(i * 13 + 1));
            m_ready = 1'($urandom_range(0, 1));
            tick(1);
        end
        m_ready = 1'b1;
        tick(20);
        check("t7_words", seen_data.size(), 40);
        check("t7_pkt_cnt", pkt_cnt, 16'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_drain.md
# fifo_rd_drain

Read-side drain stage placed directly downstream of the 8-bit asynchronous FIFO, in the read clock domain. It pops words from the FIFO's `rd_en`/`empty` read port, absorbs the FIFO's one-cycle read latency in a 3-entry buffer, and presents the words as a valid/ready stream at one word per cycle. Words are grouped into fixed-length packets, with a last-beat marker and a completed-packet counter.

## Interface

**Parameters**
- `WIDTH`, 8: data word width; matches the FIFO.
- `PKT_LEN`, 4: words per packet, range 2..256.

**Ports**
- `clk_i`, in, 1: read-domain clock, the same clock as the FIFO read side.
- `rst_n_i`, in, 1: reset, asynchronous, active-low.
- `fifo_rdata_i`, in, WIDTH: FIFO read data. Valid in the cycle after a sampled `fifo_rd_en_o`.
- `fifo_empty_i`, in, 1: FIFO empty flag.
- `fifo_rd_en_o`, out, 1: FIFO pop request.
- `flush_i`, in, 1: synchronous flush; drops all buffered and in-flight words.
- `m_data_o`, out, WIDTH: stream data.
- `m_valid_o`, out, 1: stream valid.
- `m_ready_i`, in, 1: stream ready.
- `m_last_o`, out, 1: marks the final word of a packet; qualified by `m_valid_o`.
- `pkt_cnt_o`, out, 16: number of completed packets; wraps modulo 2^16.
- `chk_o`, out, WIDTH: packet checksum (see Configuration).
- `chk_valid_o`, out, 1: one-cycle pulse when `chk_o` is valid.

## Operation

**State**
- `occ`: buffer occupancy, 0..3.
- `inflight`: 1-bit flag; set when a pop was issued in the previous cycle.
- `beat`: 0..PKT_LEN-1, a count of output handshakes within the current packet.

**Buffer and pop control**
- Pop rule: `fifo_rd_en_o = !fifo_empty_i && !flush_i && (occ + inflight < 3)`.
  - The rule depends only on registers plus `fifo_empty_i`; there is no combinational path from `m_ready_i`.
- Never pop while `fifo_empty_i` = 1.
- Capture: when `inflight` = 1, `fifo_rdata_i` is written into the buffer at the next edge, unless a flush is active.
- Output handshake: an output word is consumed on an edge where `m_valid_o && m_ready_i`.
- The buffer is a 3-entry circular FIFO.
  - `m_data_o` is the head entry.
  - `m_valid_o = (occ != 0)`.
  - A capture and a consume on the same edge leave `occ` unchanged.

**Packet framing**
- `m_last_o = m_valid_o && (beat == PKT_LEN-1)`.
- On each output handshake:
  - if `beat == PKT_LEN-1`, `beat` goes to 0 and `pkt_cnt_o` increments;
  - otherwise `beat` increments.

**Flush**
- Sampled at an edge, a flush clears `occ`, `beat` and the buffer pointers.
- An in-flight word that returns during the flush cycle or the cycle after is discarded.
- `pkt_cnt_o` is not changed.
- A handshake in the flush cycle is honoured for `pkt_cnt_o` only if it completes a packet.

**Reset**
- Asserting `rst_n_i` low, including mid-packet, forces every register to 0 immediately:
  - `m_valid_o`, `m_last_o`, `m_data_o` = 0
  - `pkt_cnt_o` = 0
  - `chk_o`, `chk_valid_o` = 0
  - `inflight`, `occ` = 0
- `fifo_rd_en_o` is 0 while reset is asserted.

## Timing

- Pop sampled at edge N. FIFO data is valid after edge N and is captured at edge N+1.
- With `occ` = 0 beforehand, `m_valid_o` rises after edge N+1. Pop-to-output latency is 1 cycle.
- Sustained throughput is 1 word per cycle while the FIFO is non-empty and `m_ready_i` = 1.
  - Steady state: `occ` = 1 or 2 and `inflight` = 1.
- With `m_ready_i` held low, popping stops once `occ + inflight` = 3. The buffer never overflows.
- Stream rule: once `m_valid_o` is high, `m_data_o` and `m_last_o` are stable until the handshake.
- FIFO empty mid-stream: `m_valid_o` drops after the buffer drains, and `beat` is preserved across the gap.
- `beat` wraps from PKT_LEN-1 to 0. `pkt_cnt_o` wraps from 16'hFFFF to 0.

## Configuration

Feature macro: `FIFO_RD_DRAIN_CHKSUM_EN`.

**Defined**
- A running XOR of every handshaked word in the packet is maintained.
- On the last-beat handshake:
  - `chk_o` registers the XOR including the last word;
  - `chk_valid_o` pulses high for exactly one cycle;
  - the accumulator clears.
- Flush and reset clear the accumulator.

**Undefined**
- The accumulator logic is removed.
- `chk_o` is tied to 0 and `chk_valid_o` is tied to 0.
- All other behaviour is identical.

## Test plan

1. **Reset values:** reset while the FIFO holds 5 words -> all outputs 0 and `fifo_rd_en_o` = 0 during reset; draining resumes only after `rst_n_i` goes high.
2. **Full-rate drain:** 8 words 0x11..0x88 in the FIFO, `m_ready_i` = 1 -> 8 consecutive valid cycles in order; `m_last_o` on 0x44 and 0x88; `pkt_cnt_o` = 2.
3. **Backpressure:** `m_ready_i` = 0 with 10 words in the FIFO -> exactly 3 pops, `m_data_o` holds the first word, and no data is lost or duplicated after ready is raised.
4. **Empty gap:** write 2 words, then 2 more after 10 idle cycles -> `m_valid_o` gap in between; `m_last_o` on the 4th word; `pkt_cnt_o` = 1.
5. **Flush:** flush asserted while `occ` = 2 and `inflight` = 1 -> `m_valid_o` = 0 next cycle; the in-flight word is dropped; the next word starts at `beat` 0.
6. **Checksum (macro defined):** packet 0x01, 0x02, 0x04, 0x08 -> `chk_o` = 0x0F with a one-cycle `chk_valid_o` on the last handshake. With the macro undefined, both outputs stay 0.
